// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass filter family: limits, accumulator
// sizing and the common sign-extension helper.
package lpf_pkg;

   localparam int LPF_MAX_LOG2_N = 8;
   localparam int LPF_MAX_NBIT   = 32;
   localparam int LPF_EXT_W      = LPF_MAX_NBIT + LPF_MAX_LOG2_N + 1;

   function automatic int ACC_W(input int nbit, input int log2_n);
      return nbit + log2_n + 1;
   endfunction

   // Treat the low nbit bits of val as signed and widen to LPF_EXT_W.
   function automatic logic signed [LPF_EXT_W-1:0] lpf_sext(
      input logic [LPF_MAX_NBIT-1:0] val,
      input int                      nbit
   );
      logic signed [LPF_EXT_W-1:0] tmp;
      tmp = $signed({{(LPF_EXT_W-LPF_MAX_NBIT){1'b0}}, val} << (LPF_EXT_W - nbit));
      return tmp >>> (LPF_EXT_W - nbit);
   endfunction

endpackage

// File: rtl/lpf_mavg_delay_line.sv
// Circular sample buffer for the moving-average filter; exposes the entry
// about to be overwritten so the caller can retire it from its running sum.
module lpf_delay_line
   import lpf_pkg::*;
#(
   parameter int NBIT   = 32,
   parameter int LOG2_N = 5
) (
   input  logic            i_clock,
   input  logic            i_RESET,
   input  logic            i_clear,
   input  logic            i_push,
   input  logic [NBIT-1:0] i_data,
   output logic [NBIT-1:0] o_oldest
);

   localparam int N  = 1 << LOG2_N;
   localparam int PW = (LOG2_N == 0) ? 1 : LOG2_N;

   logic [NBIT-1:0] mem_q [N];
   logic [PW-1:0]   wptr_q;
   logic [PW-1:0]   wptr_d;

   // Next write position, wrapping at the end of the window.
   always_comb begin
      if (wptr_q == PW'(N - 1)) begin
         wptr_d = {PW{1'b0}};
      end else begin
         wptr_d = wptr_q + PW'(1);
      end
   end

   // Buffer storage and write pointer; flushed entries read as zero.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         for (int i = 0; i < N; i++) mem_q[i] <= {NBIT{1'b0}};
         wptr_q <= {PW{1'b0}};
      end else if (i_clear) begin
         for (int i = 0; i < N; i++) mem_q[i] <= {NBIT{1'b0}};
         wptr_q <= {PW{1'b0}};
      end else if (i_push) begin
         mem_q[wptr_q] <= i_data;
         wptr_q        <= wptr_d;
      end
   end

   assign o_oldest = mem_q[wptr_q];

endmodule

// File: rtl/lpf_mavg.sv
// Power-of-two moving-average filter with a running-sum accumulator.
// Define LPF_MAVG_ROUND_EN for round-half-up output instead of floor.
module lpf_mavg
   import lpf_pkg::*;
#(
   parameter int NBIT   = 32,
   parameter int LOG2_N = 5
) (
   input  logic            i_clock,
   input  logic            i_RESET,
   input  logic            i_clear,
   input  logic            i_valid,
   input  logic [NBIT-1:0] i_data,
   output logic [NBIT-1:0] o_mean,
   output logic            o_valid,
   output logic            o_full
);

   localparam int N  = 1 << LOG2_N;
   localparam int AW = ACC_W(NBIT, LOG2_N);
   localparam int CW = LOG2_N + 1;

   logic                 accept;
   logic [NBIT-1:0]      oldest;
   logic signed [AW-1:0] acc_q;
   logic signed [AW-1:0] acc_d;
   logic signed [AW-1:0] biased;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic [NBIT-1:0]      mean_q;
   logic [NBIT-1:0]      mean_d;
   logic                 valid_q;
   logic                 full_q;
   logic                 full_d;

   assign accept = i_valid & ~i_clear;

   lpf_delay_line #(
      .NBIT   (NBIT),
      .LOG2_N (LOG2_N)
   ) u_delay_line (
      .i_clock  (i_clock),
      .i_RESET  (i_RESET),
      .i_clear  (i_clear),
      .i_push   (accept),
      .i_data   (i_data),
      .o_oldest (oldest)
   );

   // Running sum update, optional rounding bias and scaling to the mean.
   always_comb begin
      acc_d = acc_q
            + AW'(lpf_sext(LPF_MAX_NBIT'(i_data), NBIT))
            - AW'(lpf_sext(LPF_MAX_NBIT'(oldest), NBIT));
`ifdef LPF_MAVG_ROUND_EN
      biased = acc_d + AW'((1 << LOG2_N) >> 1);
`else
      biased = acc_d;
`endif
      mean_d = NBIT'(biased >>> LOG2_N);
   end

   // Saturating fill counter; full once the whole window holds real samples.
   always_comb begin
      if (cnt_q == CW'(N)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      full_d = (cnt_d == CW'(N));
   end

   // Accumulator, fill state and registered outputs.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         acc_q   <= {AW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         mean_q  <= {NBIT{1'b0}};
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else if (i_clear) begin
         acc_q   <= {AW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         mean_q  <= {NBIT{1'b0}};
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else if (i_valid) begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mean_q  <= mean_d;
         valid_q <= 1'b1;
         full_q  <= full_d;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign o_mean  = mean_q;
   assign o_valid = valid_q;
   assign o_full  = full_q;

endmodule

// File: tb/tb_lpf_mavg.sv
// Self-checking bench for lpf_mavg: directed vector table, reset corner cases
// and randomized traffic against a queue-based window-average model.
module tb_lpf_mavg;

   localparam int N = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr   = 1'b0;
   logic        vld   = 1'b0;
   logic [15:0] din   = 16'h0000;

   logic [15:0] mean4;
   logic        ov4;
   logic        of4;
   logic [15:0] mean1;
   logic        ov1;
   logic        of1;

   always #5 clk = ~clk;

   lpf_mavg #(.NBIT(16), .LOG2_N(2)) dut (
      .i_clock (clk),
      .i_RESET (rst_n),
      .i_clear (clr),
      .i_valid (vld),
      .i_data  (din),
      .o_mean  (mean4),
      .o_valid (ov4),
      .o_full  (of4)
   );

   lpf_mavg #(.NBIT(16), .LOG2_N(0)) dut1 (
      .i_clock (clk),
      .i_RESET (rst_n),
      .i_clear (clr),
      .i_valid (vld),
      .i_data  (din),
      .o_mean  (mean1),
      .o_valid (ov1),
      .o_full  (of1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: the window as a plain list of accepted samples.
   int win[$];
   int m_mean  = 0;
   bit m_valid = 1'b0;
   bit m_full  = 1'b0;
   int m1_mean = 0;
   bit m1_full = 1'b0;

   typedef struct {
      bit          v;
      bit          c;
      logic [15:0] d;
      int          e_floor;
      int          e_round;
      bit          e_valid;
      bit          e_full;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int floor_div(input longint s, input int n);
      longint q;
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return int'(q);
   endfunction

   function automatic int window_mean();
      longint s = 0;
      foreach (win[i]) s += win[i];
`ifdef LPF_MAVG_ROUND_EN
      s += N / 2;
`endif
      return floor_div(s, N);
   endfunction

   task automatic model_reset();
      win.delete();
      m_mean  = 0;
      m_valid = 1'b0;
      m_full  = 1'b0;
      m1_mean = 0;
      m1_full = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit c, input logic [15:0] d);
      if (c) begin
         model_reset();
      end else if (v) begin
         win.push_back(int'($signed(d)));
         if (win.size() > N) void'(win.pop_front());
         m_mean  = window_mean();
         m_valid = 1'b1;
         m_full  = (win.size() == N);
         m1_mean = int'($signed(d));
         m1_full = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   // Called at a falling edge: apply inputs, let one rising edge pass.
   task automatic drive(input bit v, input bit c, input logic [15:0] d);
      vld = v;
      clr = c;
      din = d;
      @(posedge clk);
      model_step(v, c, d);
      @(negedge clk);
   endtask

   task automatic check_pass_through(input string tag);
      check({tag, " n1 mean"},  int'($signed(mean1)), m1_mean);
      check({tag, " n1 valid"}, int'(ov1), int'(m_valid));
      check({tag, " n1 full"},  int'(of1), int'(m1_full));
   endtask

   task automatic check_model(input string tag);
      check({tag, " mean"},  int'($signed(mean4)), m_mean);
      check({tag, " valid"}, int'(ov4), int'(m_valid));
      check({tag, " full"},  int'(of4), int'(m_full));
      check_pass_through(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " mean"},     int'(mean4), 0);
      check({tag, " valid"},    int'(ov4), 0);
      check({tag, " full"},     int'(of4), 0);
      check({tag, " n1 mean"},  int'(mean1), 0);
      check({tag, " n1 valid"}, int'(ov1), 0);
      check({tag, " n1 full"},  int'(of1), 0);
   endtask

   task automatic add(input bit v, input bit c, input logic [15:0] d,
                      input int ef, input int er, input bit ev, input bit eu);
      vec_t r;
      r.v = v; r.c = c; r.d = d;
      r.e_floor = ef; r.e_round = er; r.e_valid = ev; r.e_full = eu;
      tbl.push_back(r);
   endtask

   initial begin
      int exp_mean;
      logic [31:0] rnd;
      logic [15:0] rd;

      // Step response
      add(1, 0, 16'd100, 25, 25, 1, 0);
      add(1, 0, 16'd100, 50, 50, 1, 0);
      add(1, 0, 16'd100, 75, 75, 1, 0);
      add(1, 0, 16'd100, 100, 100, 1, 1);
      add(0, 0, 16'd0, 100, 100, 0, 1);
      add(1, 1, 16'd50, 0, 0, 0, 0);
      // Wrap-around with a fractional final average
      add(1, 0, 16'd1, 0, 0, 1, 0);
      add(1, 0, 16'd2, 0, 1, 1, 0);
      add(1, 0, 16'd3, 1, 2, 1, 0);
      add(1, 0, 16'd4, 2, 3, 1, 1);
      add(1, 0, 16'd5, 3, 4, 1, 1);
      add(0, 1, 16'd0, 0, 0, 0, 0);
      // Negative sample, then gaps: valid pattern 1,0,0,1
      add(1, 0, 16'hFFFB, -2, -1, 1, 0);
      add(0, 0, 16'h1234, -2, -1, 0, 0);
      add(0, 0, 16'h4321, -2, -1, 0, 0);
      add(1, 0, 16'd7, 0, 1, 1, 0);
      add(0, 1, 16'd0, 0, 0, 0, 0);
      // Full-scale extremes in both directions
      add(1, 0, 16'h7FFF, 8191, 8192, 1, 0);
      add(1, 0, 16'h7FFF, 16383, 16384, 1, 0);
      add(1, 0, 16'h7FFF, 24575, 24575, 1, 0);
      add(1, 0, 16'h7FFF, 32767, 32767, 1, 1);
      add(1, 0, 16'h8000, 16383, 16383, 1, 1);
      add(1, 0, 16'h8000, -1, 0, 1, 1);
      add(1, 0, 16'h8000, -16385, -16384, 1, 1);
      add(1, 0, 16'h8000, -32768, -32768, 1, 1);
      add(0, 1, 16'd0, 0, 0, 0, 0);

      // Reset state while reset is held
      #12;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].d);
`ifdef LPF_MAVG_ROUND_EN
         exp_mean = tbl[i].e_round;
`else
         exp_mean = tbl[i].e_floor;
`endif
         check($sformatf("row%0d mean", i),  int'($signed(mean4)), exp_mean);
         check($sformatf("row%0d valid", i), int'(ov4), int'(tbl[i].e_valid));
         check($sformatf("row%0d full", i),  int'(of4), int'(tbl[i].e_full));
         check_pass_through($sformatf("row%0d", i));
      end

      // Asynchronous reset after three samples, then a fresh start
      drive(1, 0, 16'd10);
      drive(1, 0, 16'd20);
      drive(1, 0, 16'd30);
      check_model("pre-reset");
      rst_n = 1'b0;
      #1;
      check_zero("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(1, 0, 16'd40);
      check_model("post-reset first");
      check("post-reset value", int'($signed(mean4)), 10);

      // Randomized traffic with occasional clears and full-scale samples
      for (int i = 0; i < 400; i++) begin
         rnd = $urandom();
         case ($urandom_range(0, 7))
            0:       rd = 16'h7FFF;
            1:       rd = 16'h8000;
            default: rd = rnd[15:0];
         endcase
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, rd);
         check_model($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
